// File: rtl/alu_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding,
// serial-in fill-mode codes, register geometry and amount saturation.
package alu_pkg;

  localparam int REG_WIDTH = 8;
  localparam int MAX_SHIFT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam logic [1:0] FILL_ZERO = 2'b00;
  localparam logic [1:0] FILL_ONE  = 2'b01;
  localparam logic [1:0] FILL_ROT  = 2'b10;

  // Clamp a requested shift count to the register width.
  function automatic logic [3:0] sat_amount(input logic [3:0] amt);
    return (amt > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : amt;
  endfunction

endpackage

// File: rtl/shift_counter.sv
// Loadable 4-bit down-counter. tc flags the last pass (count == 1);
// the counter never wraps below zero.
module shift_counter (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  output logic [3:0] count,
  output logic       tc
);

  // Load takes priority over decrement; hold at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign tc = (count == 4'd1);

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer driving an external 8-bit load/shift register.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN (fill 10 feeds q_msb back as D0;
// without it fill 10 is zero fill and q_msb is ignored).
//
// Handshake: start is sampled only while busy is low (IDLE); a request is
// accepted on the rising edge where start=1 in IDLE, busy rises the next
// cycle and stays high through DONE. Requests while busy are dropped.
module shift_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       fill_mode,
  input  logic             q_msb,
  output logic             busy,
  output logic             done,
  output logic             load,
  output logic [WIDTH-1:0] load_data,
  output logic             shift,
  output logic             D0,
  output seq_state_e       state
);

  logic [1:0] fill_q;
  logic [3:0] count;
  logic       count_tc;
  logic       accept;
  logic       fill_bit;

  assign accept = (state == ST_IDLE) && start;

  shift_counter u_counter (
    .clk        (clk),
    .resetn     (resetn),
    .load       (accept),
    .load_value (sat_amount(amount)),
    .dec        (state == ST_SHIFT),
    .count      (count),
    .tc         (count_tc)
  );

  // Moore FSM with registered control outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      load      <= 1'b0;
      shift     <= 1'b0;
      load_data <= '0;
      fill_q    <= FILL_ZERO;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            load_data <= data_in;
            fill_q    <= fill_mode;
            load      <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          load <= 1'b0;
          if (count != 4'd0) begin
            shift <= 1'b1;
            state <= ST_SHIFT;
          end else begin
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_SHIFT: begin
          if (count_tc) begin
            shift <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef SHIFT_SEQ_ROTATE_EN
  // Rotate path absent: feedback pin intentionally left dangling.
  logic unused_q_msb;
  assign unused_q_msb = q_msb;
`endif

  // Serial-in source selection; reserved code falls back to zero fill.
  always_comb begin
    fill_bit = 1'b0;
    case (fill_q)
      FILL_ONE: fill_bit = 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
      FILL_ROT: fill_bit = q_msb;
`endif
      default:  fill_bit = 1'b0;
    endcase
  end

  assign D0 = shift & fill_bit;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural model of the
// downstream 8-bit load/shift register closing the q_msb loop.
module tb_shift_sequencer;
  import alu_pkg::*;

  logic       clk;
  logic       resetn;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] amount;
  logic [1:0] fill_mode;
  logic       q_msb;
  logic       busy;
  logic       done;
  logic       load;
  logic [7:0] load_data;
  logic       shift;
  logic       D0;
  seq_state_e state;

  logic [7:0] reg_q;

  int n_vec;
  int n_bad;

  // results of the last run_seq call
  int         r_load_cyc;
  int         r_load_cnt;
  int         r_shift_cnt;
  int         r_done_cyc;
  int         r_done_cnt;
  int         r_idle_cyc;
  int         r_viol;
  logic [7:0] r_q;

  shift_sequencer dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .data_in   (data_in),
    .amount    (amount),
    .fill_mode (fill_mode),
    .q_msb     (q_msb),
    .busy      (busy),
    .done      (done),
    .load      (load),
    .load_data (load_data),
    .shift     (shift),
    .D0        (D0),
    .state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream register model
  always @(posedge clk or negedge resetn) begin
    if (!resetn)    reg_q <= 8'h00;
    else if (load)  reg_q <= load_data;
    else if (shift) reg_q <= {reg_q[6:0], D0};
  end
  assign q_msb = reg_q[7];

  // Issue one request and observe it until busy drops. Cycle k is the
  // k-th falling edge after the accepting rising edge. At cycle poke_cyc
  // start is raised with a 0xFF/amount-1 request: for one cycle, or held
  // through the end of the sequence when hold is set.
  task automatic run_seq(input logic [7:0] d, input logic [3:0] a,
                         input logic [1:0] f, input int poke_cyc,
                         input bit hold);
    r_load_cyc = -1; r_load_cnt = 0; r_shift_cnt = 0; r_done_cyc = -1;
    r_done_cnt = 0; r_idle_cyc = -1; r_viol = 0; r_q = 8'hxx;
    @(negedge clk);
    data_in = d; amount = a; fill_mode = f; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (load) begin
        r_load_cnt++;
        if (r_load_cyc < 0) r_load_cyc = cyc;
      end
      if (shift) r_shift_cnt++;
      if (load && shift) r_viol++;
      if (!shift && D0) r_viol++;
      if (done) begin
        r_done_cnt++;
        r_done_cyc = cyc;
        r_q = reg_q;
      end
      if (!busy) begin
        r_idle_cyc = cyc;
        break;
      end
      if (cyc == poke_cyc) begin
        start = 1'b1; data_in = 8'hFF; amount = 4'd1;
      end else if (!hold) begin
        start = 1'b0;
      end
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; data_in = 8'h00; amount = 4'd0; fill_mode = 2'b00;
    resetn = 1'b0;
    #12;
    n_vec++; if ({busy, done, load, shift, D0} !== 5'b0) begin n_bad++;
      $display("FAIL reset_ctrl: got %b need 00000", {busy, done, load, shift, D0}); end
    n_vec++; if (load_data !== 8'h00) begin n_bad++;
      $display("FAIL reset_load_data: got %h need 00", load_data); end
    n_vec++; if (state !== ST_IDLE) begin n_bad++;
      $display("FAIL reset_state: got %0d need 0", state); end
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    n_vec++; if ({busy, done, load, shift} !== 4'b0) begin n_bad++;
      $display("FAIL idle_after_reset: got %b need 0000", {busy, done, load, shift}); end
  endtask

  task automatic test_basic();
    run_seq(8'h81, 4'd1, 2'b00, 0, 1'b0);
    n_vec++; if (r_load_cyc !== 1) begin n_bad++;
      $display("FAIL basic_load_cyc: got %0d need 1", r_load_cyc); end
    n_vec++; if (r_shift_cnt !== 1) begin n_bad++;
      $display("FAIL basic_shifts: got %0d need 1", r_shift_cnt); end
    n_vec++; if (r_done_cyc !== 3) begin n_bad++;
      $display("FAIL basic_done_cyc: got %0d need 3", r_done_cyc); end
    n_vec++; if (r_q !== 8'h02) begin n_bad++;
      $display("FAIL basic_q: got %h need 02", r_q); end
    n_vec++; if (r_idle_cyc !== 4) begin n_bad++;
      $display("FAIL basic_idle_cyc: got %0d need 4", r_idle_cyc); end
    n_vec++; if (load_data !== 8'h81) begin n_bad++;
      $display("FAIL basic_load_data_hold: got %h need 81", load_data); end
    n_vec++; if (r_viol !== 0) begin n_bad++;
      $display("FAIL basic_pin_rules: got %0d need 0", r_viol); end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_q;
`ifdef SHIFT_SEQ_ROTATE_EN
    exp_q = 8'h03;
`else
    exp_q = 8'h02;
`endif
    run_seq(8'h81, 4'd1, 2'b10, 0, 1'b0);
    n_vec++; if (r_q !== exp_q) begin n_bad++;
      $display("FAIL rotate_q: got %h need %h", r_q, exp_q); end
    n_vec++; if (r_viol !== 0) begin n_bad++;
      $display("FAIL rotate_pin_rules: got %0d need 0", r_viol); end
  endtask

  task automatic test_zero_amount();
    run_seq(8'h5A, 4'd0, 2'b01, 0, 1'b0);
    n_vec++; if (r_shift_cnt !== 0) begin n_bad++;
      $display("FAIL zero_shifts: got %0d need 0", r_shift_cnt); end
    n_vec++; if (r_done_cyc !== 2) begin n_bad++;
      $display("FAIL zero_done_cyc: got %0d need 2", r_done_cyc); end
    n_vec++; if (r_q !== 8'h5A) begin n_bad++;
      $display("FAIL zero_q: got %h need 5a", r_q); end
  endtask

  task automatic test_saturate();
    run_seq(8'h00, 4'd12, 2'b01, 0, 1'b0);
    n_vec++; if (r_shift_cnt !== 8) begin n_bad++;
      $display("FAIL sat12_shifts: got %0d need 8", r_shift_cnt); end
    n_vec++; if (r_done_cyc !== 10) begin n_bad++;
      $display("FAIL sat12_done_cyc: got %0d need 10", r_done_cyc); end
    n_vec++; if (r_q !== 8'hFF) begin n_bad++;
      $display("FAIL sat12_q: got %h need ff", r_q); end
    run_seq(8'hFF, 4'd9, 2'b00, 0, 1'b0);
    n_vec++; if (r_shift_cnt !== 8) begin n_bad++;
      $display("FAIL sat9_shifts: got %0d need 8", r_shift_cnt); end
    n_vec++; if (r_q !== 8'h00) begin n_bad++;
      $display("FAIL sat9_q: got %h need 00", r_q); end
    run_seq(8'h01, 4'd7, 2'b01, 0, 1'b0);
    n_vec++; if (r_q !== 8'hFF || r_shift_cnt !== 7) begin n_bad++;
      $display("FAIL amt7: got q=%h shifts=%0d need q=ff shifts=7", r_q, r_shift_cnt); end
  endtask

  task automatic test_reserved_fill();
    run_seq(8'hC3, 4'd2, 2'b11, 0, 1'b0);
    n_vec++; if (r_q !== 8'h0C) begin n_bad++;
      $display("FAIL fill11_q: got %h need 0c", r_q); end
  endtask

  task automatic test_start_ignored();
    run_seq(8'h0F, 4'd4, 2'b00, 3, 1'b0);
    n_vec++; if (r_q !== 8'hF0) begin n_bad++;
      $display("FAIL busy_start_q: got %h need f0", r_q); end
    n_vec++; if (r_done_cnt !== 1 || r_load_cnt !== 1) begin n_bad++;
      $display("FAIL busy_start_counts: got done=%0d load=%0d need 1/1", r_done_cnt, r_load_cnt); end
    n_vec++; if (r_done_cyc !== 6) begin n_bad++;
      $display("FAIL busy_start_done_cyc: got %0d need 6", r_done_cyc); end
    // start pulsed only in the DONE cycle must not launch anything
    run_seq(8'h33, 4'd1, 2'b00, 3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (busy !== 1'b0 || load_data !== 8'h33) begin n_bad++;
      $display("FAIL done_start_ignored: got busy=%b data=%h need 0/33", busy, load_data); end
  endtask

  task automatic test_back_to_back();
    int got;
    // start raised in DONE and held: taken on the following IDLE edge
    run_seq(8'h11, 4'd1, 2'b00, 3, 1'b1);
    n_vec++; if (r_idle_cyc !== 4) begin n_bad++;
      $display("FAIL b2b_first_idle: got %0d need 4", r_idle_cyc); end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_vec++; if (busy !== 1'b1 || load !== 1'b1 || load_data !== 8'hFF) begin n_bad++;
      $display("FAIL b2b_second_accept: got busy=%b load=%b data=%h need 1/1/ff", busy, load, load_data); end
    got = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      @(negedge clk);
      if (done) got++;
    end
    n_vec++; if (got !== 1 || busy !== 1'b0 || reg_q !== 8'hFE) begin n_bad++;
      $display("FAIL b2b_second_result: got done=%0d busy=%b q=%h need 1/0/fe", got, busy, reg_q); end
  endtask

  task automatic test_reset_mid();
    int got;
    got = 0;
    @(negedge clk);
    data_in = 8'h0F; amount = 4'd4; fill_mode = 2'b01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    // two shift edges have now occurred
    @(negedge clk);
    n_vec++; if (reg_q !== 8'h3F || shift !== 1'b1) begin n_bad++;
      $display("FAIL midreset_pre: got q=%h shift=%b need 3f/1", reg_q, shift); end
    resetn = 1'b0;
    #1;
    n_vec++; if ({busy, done, load, shift, D0} !== 5'b0 || load_data !== 8'h00 || reg_q !== 8'h00) begin n_bad++;
      $display("FAIL midreset_outputs: got ctrl=%b data=%h q=%h need 00000/00/00",
               {busy, done, load, shift, D0}, load_data, reg_q); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) got++;
    end
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) got++;
    end
    n_vec++; if (got !== 0) begin n_bad++;
      $display("FAIL midreset_no_done: got %0d need 0", got); end
    run_seq(8'h81, 4'd1, 2'b01, 0, 1'b0);
    n_vec++; if (r_q !== 8'h03 || r_done_cyc !== 3) begin n_bad++;
      $display("FAIL post_reset_run: got q=%h done_cyc=%0d need 03/3", r_q, r_done_cyc); end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_rotate();
    test_zero_amount();
    test_saturate();
    test_reserved_fill();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Control stage directly upstream of the 8-bit load/shift register. It accepts a shift request (operand, shift amount, fill mode) over a start/busy handshake. It then drives the register's load, shift and serial-in pins for exactly the right number of cycles and pulses `done` when the register holds the result. Each left shift moves Q[i-1] into Q[i], and the serial-in bit enters at bit 0.

## Interface
Parameters:
- `WIDTH`, 8, register width; fixed at 8 for this block
- `AMT_W`, 4, width of the shift-amount input

Ports:
- `clk`  in  1  system clock, rising edge
- `resetn`  in  1  asynchronous active-low reset
- `start`  in  1  request strobe; sampled only in IDLE
- `data_in`  in  8  operand, captured when a request is accepted
- `amount`  in  4  requested left-shift count, captured with `data_in`
- `fill_mode`  in  2  serial-in source: 00 zero, 01 one, 10 rotate (Q[7]), 11 reserved (treated as zero)
- `q_msb`  in  1  Q[7] fed back from the downstream register
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse; the register holds the final value
- `load`  out  1  to register `load`
- `load_data`  out  8  to register `load_data`
- `shift`  out  1  to register `shift`
- `D0`  out  1  to register serial-in `D0`

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - If `start`=1: capture `data_in`, `fill_mode` and the saturated amount (min(`amount`, 8)), then go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - `load`=1 and `load_data`=captured operand for one cycle.
  - Go to SHIFT if the count is > 0, else to DONE.
- SHIFT:
  - `shift`=1 every cycle; the down-counter decrements each cycle.
  - Go to DONE on the cycle the count reaches 1.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` is ignored in LOAD, SHIFT and DONE. No queueing; the requester must wait for `busy`=0.
- `D0` source:
  - fill 00: 0.
  - fill 01: 1.
  - fill 10: combinational copy of `q_msb` (rotate left).
- `D0` is meaningful only while `shift`=1 and is driven 0 otherwise.
- `load` and `shift` are never high in the same cycle.
- `load_data` holds the captured operand from LOAD until the next accept, and is 0 after reset.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `busy`, `done`, `load`, `shift`, `D0` go to 0; `load_data` and the counter go to 0.
  - A reset during a sequence aborts it and no `done` is issued. The register shares `resetn`, so both return to zero together.
- Control outputs are registered (Moore); `D0` in rotate mode is combinational from `q_msb`.
- Cycle timing for a request accepted at edge 0 with saturated count N:
  - `load` high in cycle 1.
  - `shift` high in cycles 2..N+1.
  - `done` high in cycle N+2.
  - IDLE again in cycle N+3.
- Total latency from accept to `done` is N+2 cycles; N=0 gives 2 cycles.
- `busy` rises the cycle after accept and falls the cycle after `done`.
- Boundaries:
  - `amount` 9..15 saturates to 8.
  - `start` asserted in the DONE cycle is ignored; it is accepted the next cycle if still high.

## Configuration
- Macro: `SHIFT_SEQ_ROTATE_EN`.
- Defined: fill 10 selects `q_msb` as `D0` (rotate).
- Undefined: the rotate path is removed, fill 10 behaves as zero fill, and `q_msb` is left unused (no logic depends on it).

## Structure
- Shared package `alu_pkg`:
  - FSM state encoding (IDLE=0, LOAD=1, SHIFT=2, DONE=3).
  - Fill-mode constants (FILL_ZERO, FILL_ONE, FILL_ROT).
  - `REG_WIDTH`=8 and `MAX_SHIFT`=8.
- One sub-module: `shift_counter`, a 4-bit loadable down-counter with a terminal-count flag, used for the SHIFT-phase count.

## Test plan
- `data_in`=0x81, `amount`=1, fill 00 → `load` in cycle 1, one `shift` cycle, register Q=0x02, `done` in cycle 3.
- `data_in`=0x81, `amount`=1, fill 10 (macro defined) → Q=0x03; with the macro undefined → Q=0x02.
- `data_in`=0x5A, `amount`=0 → no `shift` cycles, Q=0x5A, `done` 2 cycles after accept.
- `data_in`=0x00, `amount`=12, fill 01 → exactly 8 `shift` cycles, Q=0xFF, `done` 10 cycles after accept.
- Pulse `start` during SHIFT with `data_in`=0xFF → ignored; the first sequence completes with an unchanged result and only one `done`.
- Drive `resetn`=0 mid-SHIFT (after 2 of 4 shifts) → all outputs 0 immediately, no `done`; a new `start` after release runs a full sequence correctly.
